// File: rtl/text_console_writer_pkg.sv
// rtl/text_console_writer_pkg.sv - shared console constants, state and op types
package text_console_writer_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL,
    ST_CLEAR
  } state_e;

  // What the one-cycle WRITE state commits to the cursor.
  typedef enum logic [2:0] {
    OP_CHAR,
    OP_LF,
    OP_CR,
    OP_BS,
    OP_FF
  } op_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte stream to character memory writer with cursor and scroll
module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int AW   = $clog2(COLS*ROWS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     char_valid,
  input  logic [7:0]               char_data,
  output logic                     char_ready,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_waddr,
  output logic [7:0]               mem_wdata,
  output logic [AW-1:0]            mem_raddr,
  input  logic [7:0]               mem_rdata,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic                     busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int NCOPY = (ROWS-1)*COLS;
  localparam int LAST  = COLS*ROWS-1;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            copy_q, copy_d;
  logic            go_scroll;
  logic [AW-1:0]   cur_addr;

  assign cur_addr = AW'(row_q) * AW'(COLS) + AW'(col_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    copy_d    = 1'b0;
    go_scroll = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (char_valid) begin
          if (is_printable(char_data)) begin
            state_d = ST_WRITE;
            op_d    = OP_CHAR;
            we_d    = 1'b1;
            waddr_d = cur_addr;
            wdata_d = char_data;
          end else if (char_data == ASCII_LF) begin
            state_d = ST_WRITE;
            op_d    = OP_LF;
          end else if (char_data == ASCII_CR) begin
            state_d = ST_WRITE;
            op_d    = OP_CR;
          end else if (char_data == ASCII_FF) begin
            state_d = ST_WRITE;
            op_d    = OP_FF;
          end else if (char_data == ASCII_BS && col_q != '0) begin
            state_d = ST_WRITE;
            op_d    = OP_BS;
            we_d    = 1'b1;
            waddr_d = cur_addr - AW'(1);
            wdata_d = ASCII_SPACE;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        case (op_q)
          OP_CHAR: begin
            if (col_q == CW'(COLS-1)) begin
              col_d = '0;
              if (row_q == RW'(ROWS-1)) go_scroll = 1'b1;
              else                      row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
          OP_LF: begin
            col_d = '0;
            if (row_q == RW'(ROWS-1)) go_scroll = 1'b1;
            else                      row_d = row_q + RW'(1);
          end
          OP_CR: col_d = '0;
          OP_BS: col_d = col_q - CW'(1);
          OP_FF: begin
            col_d   = '0;
            row_d   = '0;
            state_d = ST_CLEAR;
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = ASCII_SPACE;
          end
          default: ;
        endcase
      end
      ST_SCROLL: begin
        // Read leads write by one cycle; cnt_q == NCOPY is the drain cycle of the last copy.
        if (cnt_q == AW'(NCOPY)) begin
          state_d = ST_CLEAR;
          we_d    = 1'b1;
          waddr_d = AW'(NCOPY);
          wdata_d = ASCII_SPACE;
          raddr_d = '0;
        end else begin
          we_d    = 1'b1;
          copy_d  = 1'b1;
          waddr_d = cnt_q;
          cnt_d   = cnt_q + AW'(1);
          raddr_d = raddr_q + AW'(1);
        end
      end
      ST_CLEAR: begin
        // Both the full clear and the post-scroll clear end on the last cell.
        if (waddr_q != AW'(LAST)) begin
          we_d    = 1'b1;
          waddr_d = waddr_q + AW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_scroll) begin
      state_d = ST_SCROLL;
      cnt_d   = '0;
      raddr_d = AW'(COLS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_CHAR;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      copy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      copy_q  <= copy_d;
    end
  end

  assign char_ready = (state_q == ST_IDLE);
  assign busy       = !char_ready;
  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = copy_q ? mem_rdata : wdata_q;
  assign mem_raddr  = raddr_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - directed table-driven bench for text_console_writer
module tb_text_console_writer;

  localparam int COLS = 8;
  localparam int ROWS = 3;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          char_valid = 1'b0;
  logic [7:0]    char_data = 8'h00;
  logic          char_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_rdata = 8'h00;
  logic [2:0]    cursor_col;
  logic [1:0]    cursor_row;
  logic          busy;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic [7:0] tb_mem [32];
  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  int checks = 0;
  int failures = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= tb_mem[mem_raddr];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      tb_mem[mem_waddr] = mem_wdata;
      log_addr.push_back(int'(mem_waddr));
      log_data.push_back(int'(mem_wdata));
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!char_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!char_ready) check("ready_wait_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] ch, output int base, output int nw,
                      output int acc, output int low);
    int n;
    wait_ready();
    base = log_addr.size();
    char_data = ch;
    char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    acc = cyc;
    low = 0;
    n = 0;
    while (!char_ready && n < 500) begin
      low++;
      @(posedge clk); #1; n++;
    end
    nw = log_addr.size() - base;
  endtask

  typedef struct {
    logic [7:0] ch;
    int nw; int faddr; int laddr; int ldata; int lat; int low; int col; int row;
  } vec_t;

  vec_t vt[$];

  initial begin
    int base, nw, acc, low;
    for (int i = 0; i < 32; i++) tb_mem[i] = 8'h00;

    // ch, writes, first addr, last addr, last data, latency, ready-low, col, row
    vt.push_back('{8'h41, 1, 0, 0, 8'h41, 0, 1, 1, 0});
    vt.push_back('{8'h42, 1, 1, 1, 8'h42, 0, 1, 2, 0});
    vt.push_back('{8'h08, 1, 1, 1, 8'h20, 0, 1, 1, 0});
    vt.push_back('{8'h08, 1, 0, 0, 8'h20, 0, 1, 0, 0});
    vt.push_back('{8'h08, 0, 0, 0, 0,     0, 0, 0, 0});
    vt.push_back('{8'h01, 0, 0, 0, 0,     0, 0, 0, 0});
    vt.push_back('{8'h43, 1, 0, 0, 8'h43, 0, 1, 1, 0});
    vt.push_back('{8'h0D, 0, 0, 0, 0,     0, 1, 0, 0});
    vt.push_back('{8'h0A, 0, 0, 0, 0,     0, 1, 0, 1});
    vt.push_back('{8'h44, 1, 8, 8, 8'h44, 0, 1, 1, 1});
    vt.push_back('{8'h0C, 24, 0, 23, 8'h20, 1, 25, 0, 0});
    for (int i = 0; i < 8; i++)
      vt.push_back('{8'h78, 1, i, i, 8'h78, 0, 1, (i + 1) % 8, (i == 7) ? 1 : 0});
    vt.push_back('{8'h79, 1, 8, 8, 8'h79, 0, 1, 1, 1});

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_waddr", int'(mem_waddr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    check("rst_raddr", int'(mem_raddr), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", int'(char_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_col", int'(cursor_col), 0);
    check("rst_row", int'(cursor_row), 0);

    foreach (vt[i]) begin
      send(vt[i].ch, base, nw, acc, low);
      check($sformatf("v%0d_nwrites", i), nw, vt[i].nw);
      if (nw > 0 && vt[i].nw > 0) begin
        check($sformatf("v%0d_first_addr", i), log_addr[base], vt[i].faddr);
        check($sformatf("v%0d_last_addr", i), log_addr[base+nw-1], vt[i].laddr);
        check($sformatf("v%0d_last_data", i), log_data[base+nw-1], vt[i].ldata);
        check($sformatf("v%0d_latency", i), log_cyc[base] - acc, vt[i].lat);
        check($sformatf("v%0d_burst_len", i), log_cyc[base+nw-1] - log_cyc[base] + 1, vt[i].nw);
      end
      check($sformatf("v%0d_ready_low", i), low, vt[i].low);
      check($sformatf("v%0d_col", i), int'(cursor_col), vt[i].col);
      check($sformatf("v%0d_row", i), int'(cursor_row), vt[i].row);
    end

    // Scroll: clear, fill 23 cells with distinct bytes, LF on the last row.
    send(8'h0C, base, nw, acc, low);
    for (int i = 0; i < 23; i++) send(8'h30 + 8'(i), base, nw, acc, low);
    check("fill_col", int'(cursor_col), 7);
    check("fill_row", int'(cursor_row), 2);
    send(8'h0A, base, nw, acc, low);
    check("scroll_nwrites", nw, 24);
    check("scroll_ready_low", low, 26);
    if (nw == 24) begin
      check("scroll_first_cyc", log_cyc[base] - acc, 2);
      check("scroll_last_cyc", log_cyc[base+23] - acc, 25);
      for (int k = 0; k < 24; k++)
        check($sformatf("scroll_waddr%0d", k), log_addr[base+k], k);
    end
    for (int k = 0; k < 24; k++)
      check($sformatf("scroll_mem%0d", k), int'(tb_mem[k]), (k < 15) ? 8'h38 + k : 8'h20);
    check("scroll_col", int'(cursor_col), 0);
    check("scroll_row", int'(cursor_row), 2);

    // Reset during the fifth cycle of a scroll.
    wait_ready();
    char_data = 8'h0A;
    char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_midscroll_we", int'(mem_we), 1);
    check("abort_midscroll_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    base = log_addr.size();
    check("abort_we", int'(mem_we), 0);
    check("abort_col", int'(cursor_col), 0);
    check("abort_row", int'(cursor_row), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", int'(char_ready), 1);
    check("abort_no_writes", log_addr.size() - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
